// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among GPU masters, bounded bursts, one outstanding fixed-latency read.
// Latency: 1-cycle arbitration bubble, grant combinational in ISSUE, read data RD_LATENCY+1 after issue; a master stalls by holding i_req.
// Optional DRAM_ARB_STATS_EN adds per-master saturating accepted-beat counters on o_beat_cnt.
module dram_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 2,
    parameter int BURST_MAX   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            i_req,
    input  logic [NUM_MASTERS-1:0]            i_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_MASTERS-1:0]            o_gnt,
    output logic [NUM_MASTERS-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]             o_rdata,
    output logic                              o_dram_req,
    output logic                              o_dram_we,
    output logic [ADDR_WIDTH-1:0]             o_dram_addr,
    output logic [DATA_WIDTH-1:0]             o_dram_wdata,
    input  logic [DATA_WIDTH-1:0]             i_dram_rdata,
    output logic                              o_busy
`ifdef DRAM_ARB_STATS_EN
    ,
    output logic [NUM_MASTERS*16-1:0]         o_beat_cnt
`endif
);

    localparam int PW = $clog2(NUM_MASTERS);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int RW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [PW-1:0] rr_ptr, rr_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [RW-1:0] rd_cnt, rd_nxt;
    logic [PW-1:0] winner;
    logic          win_found;
    logic [CW-1:0] cand;
    logic          xfer;
    logic          rd_done;

    assign xfer    = (state == ISSUE) && i_req[owner] && (beat_cnt < BW'(BURST_MAX));
    assign rd_done = (state == WAIT_RD) && (rd_cnt == RW'(RD_LATENCY - 1));
    assign o_busy  = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_nxt       = rr_ptr;
        beat_nxt     = beat_cnt;
        rd_nxt       = rd_cnt;
        o_gnt        = '0;
        o_dram_req   = 1'b0;
        o_dram_we    = 1'b0;
        o_dram_addr  = '0;
        o_dram_wdata = '0;
        winner       = '0;
        win_found    = 1'b0;
        cand         = '0;

        // Wrap by compare so non-power-of-two master counts rotate correctly.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(NUM_MASTERS)) cand = cand - CW'(NUM_MASTERS);
            if (!win_found && i_req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                winner    = cand[PW-1:0];
            end
        end

        case (state)
            IDLE: begin
                if (win_found) begin
                    owner_nxt = winner;
                    beat_nxt  = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    o_gnt[owner] = 1'b1;
                    o_dram_req   = 1'b1;
                    o_dram_we    = i_we[owner];
                    o_dram_addr  = i_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
                    o_dram_wdata = i_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
                    beat_nxt     = beat_cnt + BW'(1);
                    if (!i_we[owner]) begin
                        rd_nxt    = '0;
                        state_nxt = WAIT_RD;
                    end
                end else begin
                    rr_nxt    = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + PW'(1);
                    state_nxt = IDLE;
                end
            end
            WAIT_RD: begin
                if (rd_done) state_nxt = ISSUE;
                else         rd_nxt    = rd_cnt + RW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            rd_cnt   <= '0;
            o_rvalid <= '0;
            o_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
            rd_cnt   <= rd_nxt;
            o_rvalid <= '0;
            if (rd_done) begin
                o_rvalid[owner] <= 1'b1;
                o_rdata         <= i_dram_rdata;
            end
        end
    end

`ifdef DRAM_ARB_STATS_EN
    logic [15:0] stat_cnt [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_stat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                               stat_cnt[g] <= '0;
            else if (o_gnt[g] && stat_cnt[g] != 16'hFFFF) stat_cnt[g] <= stat_cnt[g] + 16'd1;
        end
        assign o_beat_cnt[g*16 +: 16] = stat_cnt[g];
    end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: master model advances beats on grant, outputs sampled on negedge.
module tb_dram_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0, we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [DW-1:0]   dram_rdata = '0;
    logic [N-1:0]    o_gnt, o_rvalid;
    logic [DW-1:0]   o_rdata, o_dram_wdata;
    logic [AW-1:0]   o_dram_addr;
    logic            o_dram_req, o_dram_we, o_busy;
`ifdef DRAM_ARB_STATS_EN
    logic [N*16-1:0] o_beat_cnt;
`endif

    dram_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .RD_LATENCY(2), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
        .o_dram_req(o_dram_req), .o_dram_we(o_dram_we),
        .o_dram_addr(o_dram_addr), .o_dram_wdata(o_dram_wdata),
        .i_dram_rdata(dram_rdata), .o_busy(o_busy)
`ifdef DRAM_ARB_STATS_EN
        , .o_beat_cnt(o_beat_cnt)
`endif
    );

    int n_chk = 0, n_pass = 0;
    int rem [N];
    logic [N-1:0]  s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata, s_dwdata;
    logic [AW-1:0] s_daddr;
    logic          s_dreq, s_dwe, s_busy;
    logic [N-1:0]  gnt_q[$];
    logic [N-1:0]  rv_q[$];
    logic          busy_q[$];
    int            exp_q[$];
    int            runs[$];
    int            cur, ngnt;
    logic [N-1:0]  rv_or;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock cycle: sample on negedge, then update the master model after the edge.
    task automatic tick();
        @(negedge clk);
        s_gnt = o_gnt; s_rvalid = o_rvalid; s_rdata = o_rdata;
        s_dreq = o_dram_req; s_dwe = o_dram_we; s_daddr = o_dram_addr;
        s_dwdata = o_dram_wdata; s_busy = o_busy;
        gnt_q.push_back(s_gnt); rv_q.push_back(s_rvalid); busy_q.push_back(s_busy);
        @(posedge clk); #1;
        for (int m = 0; m < N; m++) begin
            if (s_gnt[m] && rem[m] > 0) begin
                rem[m]--;
                addr[m*AW +: AW]  += 32'd4;
                wdata[m*DW +: DW] += 32'd1;
            end
            req[m] = (rem[m] > 0);
        end
    endtask

    task automatic start(int m, int beats, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        rem[m] = beats; we[m] = w;
        addr[m*AW +: AW] = a; wdata[m*DW +: DW] = d;
        req[m] = (beats > 0);
    endtask

    task automatic clear_logs();
        gnt_q = {}; rv_q = {}; busy_q = {}; exp_q = {};
    endtask

    task automatic do_reset();
        for (int m = 0; m < N; m++) rem[m] = 0;
        req = '0; we = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic chk_seq(string tag);
        int seq[$];
        seq = {};
        foreach (gnt_q[i])
            for (int m = 0; m < N; m++)
                if (gnt_q[i][m]) seq.push_back(m);
        chk({tag, "_len"}, seq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seq.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), seq[i], exp_q[i]);
    endtask

    function automatic int idle_between();
        int first = -1, last = -1, cnt = 0;
        foreach (gnt_q[i]) if (gnt_q[i] != '0) begin
            if (first < 0) first = i;
            last = i;
        end
        for (int i = first + 1; i < last; i++) if (!busy_q[i]) cnt++;
        return cnt;
    endfunction

    initial begin
        for (int m = 0; m < N; m++) rem[m] = 0;
        // Reset state, with every master requesting.
        req = '1;
        #1;
        chk("rst_gnt", o_gnt, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_dram_req", o_dram_req, 0);
        chk("rst_dram_addr", o_dram_addr, 0);
        chk("rst_busy", o_busy, 0);
        req = '0;

        // Test 1: single write beat from M2.
        do_reset();
        start(2, 1, 1'b1, 32'h100, 32'hDEADBEEF);
        tick();
        chk("t1_c0_busy", s_busy, 0);
        chk("t1_c0_gnt", s_gnt, 0);
        tick();
        chk("t1_c1_gnt", s_gnt, 3'b100);
        chk("t1_c1_dreq", s_dreq, 1);
        chk("t1_c1_dwe", s_dwe, 1);
        chk("t1_c1_addr", s_daddr, 32'h100);
        chk("t1_c1_wdata", s_dwdata, 32'hDEADBEEF);
        tick();
        chk("t1_c2_gnt", s_gnt, 0);
        chk("t1_c2_dreq", s_dreq, 0);
        chk("t1_c2_addr", s_daddr, 0);
        chk("t1_c2_wdata", s_dwdata, 0);
        tick();
        chk("t1_c3_busy", s_busy, 0);

        // Test 2: M0 read, data returned by DRAM only in cycle 3.
        do_reset();
        dram_rdata = 32'hBAD0;
        start(0, 1, 1'b0, 32'h40, 32'h0);
        tick();
        tick();
        chk("t2_c1_gnt", s_gnt, 3'b001);
        chk("t2_c1_dreq", s_dreq, 1);
        chk("t2_c1_dwe", s_dwe, 0);
        chk("t2_c1_addr", s_daddr, 32'h40);
        tick();
        chk("t2_c2_dreq", s_dreq, 0);
        chk("t2_c2_rvalid", s_rvalid, 0);
        dram_rdata = 32'h1234;
        tick();
        chk("t2_c3_rvalid", s_rvalid, 0);
        dram_rdata = 32'hBAD0;
        tick();
        chk("t2_c4_rvalid", s_rvalid, 3'b001);
        chk("t2_c4_rdata", s_rdata, 32'h1234);
        tick();
        chk("t2_c5_rvalid", s_rvalid, 0);
        chk("t2_c5_rdata_hold", s_rdata, 32'h1234);
        chk("t2_c5_busy", s_busy, 0);
        ngnt = 0;
        foreach (gnt_q[i]) ngnt += int'(gnt_q[i][0]);
        chk("t2_gnt_once", ngnt, 1);

        // Test 3: all masters streaming writes.
        do_reset();
        start(0, 8, 1'b1, 32'h1000, 32'hA0);
        start(1, 4, 1'b1, 32'h2000, 32'hB0);
        start(2, 4, 1'b1, 32'h3000, 32'hC0);
        repeat (26) tick();
        for (int b = 0; b < 16; b++) exp_q.push_back((b / 4 == 3) ? 0 : b / 4);
        chk_seq("t3");
        chk("t3_idle_cycles", idle_between(), 3);
`ifdef DRAM_ARB_STATS_EN
        chk("t6_beat_cnt", o_beat_cnt, {16'd4, 16'd4, 16'd8});
`endif

        // Test 4a: M1 alone, 10 beats -> bursts 4,4,2.
        do_reset();
        start(1, 10, 1'b1, 32'h4000, 32'h10);
        repeat (20) tick();
        runs = {}; cur = 0;
        foreach (gnt_q[i]) begin
            if (gnt_q[i] == 3'b010) cur++;
            else if (cur > 0) begin runs.push_back(cur); cur = 0; end
        end
        if (cur > 0) runs.push_back(cur);
        chk("t4a_nbursts", runs.size(), 3);
        if (runs.size() == 3) begin
            chk("t4a_burst0", runs[0], 4);
            chk("t4a_burst1", runs[1], 4);
            chk("t4a_burst2", runs[2], 2);
        end
        chk("t4a_idle_cycles", idle_between(), 2);

        // Test 4b: M2 arrives mid-burst and is served next.
        do_reset();
        start(1, 10, 1'b1, 32'h5000, 32'h20);
        tick(); tick();
        start(2, 2, 1'b1, 32'h6000, 32'h30);
        repeat (22) tick();
        for (int b = 0; b < 12; b++) exp_q.push_back((b == 4 || b == 5) ? 2 : 1);
        chk_seq("t4b");

        // Test 5: reset while a read is outstanding.
        do_reset();
        start(1, 1, 1'b1, 32'h7000, 32'h1);
        repeat (4) tick();
        start(0, 1, 1'b0, 32'h80, 32'h0);
        tick(); tick();
        chk("t5_rd_gnt", s_gnt, 3'b001);
        dram_rdata = 32'h5555;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_gnt", o_gnt, 0);
        chk("t5_rst_rvalid", o_rvalid, 0);
        chk("t5_rst_dreq", o_dram_req, 0);
        clear_logs();
        tick(); tick();
        rst_n = 1'b1;
        start(1, 1, 1'b1, 32'h8000, 32'h2);
        start(2, 1, 1'b1, 32'h9000, 32'h3);
        repeat (8) tick();
        exp_q.push_back(1);
        exp_q.push_back(2);
        chk_seq("t5");
        rv_or = '0;
        foreach (rv_q[i]) rv_or |= rv_q[i];
        chk("t5_no_rvalid", rv_or, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
